// File: rtl/stack_access_sequencer_pkg.sv
// Shared definitions for the stack access sequencer: request opcodes,
// sequencer states and default stack bounds.
package stack_access_sequencer_pkg;

    // Memory-stage operation codes; 3'b111 is not named and behaves as NONE.
    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_PUSH  = 3'b011,
        OP_POP   = 3'b100,
        OP_CALL  = 3'b101,
        OP_RET   = 3'b110
    } req_op_e;

    // IDLE accepts a new request; SECOND finishes the second half of CALL/RET.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } seq_state_e;

    // Top of stack (first free slot) after reset.
    localparam logic [31:0] SP_INIT_DEFAULT  = 32'h0000_0FFF;
    // Lowest legal stack address when the stack guard is built in.
    localparam logic [31:0] SP_LIMIT_DEFAULT = 32'h0000_0800;

endpackage

// File: rtl/stack_access_sequencer_if.sv
// Request and data-memory bus of the stack access sequencer.
// The master side is the pipeline plus memory; the slave side is the sequencer.
interface stack_access_sequencer_if;

    logic        req_valid;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [31:0] req_pc;
    logic [15:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [31:0] ret_pc;
    logic        ret_pc_valid;
    logic        stall;
    logic [31:0] sp;
    logic        stack_fault;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write, rd_data, rd_valid,
               ret_pc, ret_pc_valid, stall, sp, stack_fault
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write, rd_data, rd_valid,
               ret_pc, ret_pc_valid, stall, sp, stack_fault
    );

endinterface

// File: rtl/stack_access_sequencer_spu.sv
// Stack pointer unit: holds SP, applies increment/decrement/hold and
// provides the sp+1 lookahead used as the POP/RET read address.
module stack_pointer_unit
    import stack_access_sequencer_pkg::*;
#(
    parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        inc,
    input  logic        dec,
    output logic [31:0] sp,
    output logic [31:0] sp_plus1
);

    logic [31:0] sp_q;

    // SP register; arithmetic wraps modulo 2^32, increment wins if both are asked.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sp_q <= SP_INIT;
        end else if (inc) begin
            sp_q <= sp_q + 32'd1;
        end else if (dec) begin
            sp_q <= sp_q - 32'd1;
        end
    end

    assign sp       = sp_q;
    assign sp_plus1 = sp_q + 32'd1;

endmodule

// File: rtl/stack_access_sequencer.sv
// Memory-stage controller for the 16-bit data memory and the 32-bit SP.
// Issues LOAD/STORE/PUSH/POP in one cycle and splits CALL/RET into two
// 16-bit accesses, stalling upstream during the first half.
// Optional build macro: STACK_GUARD_EN (overflow/underflow guard with a
// sticky stack_fault flag).
module stack_access_sequencer
    import stack_access_sequencer_pkg::*;
#(
    parameter logic [31:0] SP_INIT  = SP_INIT_DEFAULT,
    parameter logic [31:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     Reset,
    stack_access_sequencer_if.slave  bus
);

`ifdef STACK_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    seq_state_e  state;
    seq_state_e  next_state;
    logic        held_ret;
    logic        next_held_ret;
    logic [15:0] low_half;
    logic        latch_en;
    logic        fault_q;
    logic        fault_set;
    logic        sp_inc;
    logic        sp_dec;
    logic [31:0] sp;
    logic [31:0] sp_plus1;
    logic        overflow;
    logic        underflow;

    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic        rd_valid;
    logic        ret_pc_valid;
    logic        stall;

    stack_pointer_unit #(
        .SP_INIT (SP_INIT)
    ) u_spu (
        .CLK      (CLK),
        .Reset    (Reset),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp),
        .sp_plus1 (sp_plus1)
    );

    // Guard conditions; they collapse to constant 0 when the guard is not built.
    assign overflow  = GUARD_EN && (sp < SP_LIMIT);
    assign underflow = GUARD_EN && (sp == SP_INIT);

    // State, held-op flag, RET low-half latch and sticky fault registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_IDLE;
            held_ret <= 1'b0;
            low_half <= 16'h0000;
            fault_q  <= 1'b0;
        end else begin
            state    <= next_state;
            held_ret <= next_held_ret;
            if (latch_en) begin
                low_half <= bus.mem_rdata;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Next-state and output decode; a guard fault suppresses strobes and SP updates.
    always_comb begin
        next_state    = state;
        next_held_ret = held_ret;
        mem_addr      = sp;
        mem_wdata     = bus.req_wdata;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        rd_valid      = 1'b0;
        ret_pc_valid  = 1'b0;
        stall         = 1'b0;
        sp_inc        = 1'b0;
        sp_dec        = 1'b0;
        latch_en      = 1'b0;
        fault_set     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    case (req_op_e'(bus.req_op))
                        OP_LOAD: begin
                            mem_addr = {16'h0000, bus.req_addr};
                            mem_read = 1'b1;
                            rd_valid = 1'b1;
                        end
                        OP_STORE: begin
                            mem_addr  = {16'h0000, bus.req_addr};
                            mem_write = 1'b1;
                        end
                        OP_PUSH: begin
                            if (overflow) begin
                                fault_set = 1'b1;
                            end else begin
                                mem_write = 1'b1;
                                sp_dec    = 1'b1;
                            end
                        end
                        OP_POP: begin
                            mem_addr = sp_plus1;
                            if (underflow) begin
                                fault_set = 1'b1;
                            end else begin
                                mem_read = 1'b1;
                                rd_valid = 1'b1;
                                sp_inc   = 1'b1;
                            end
                        end
                        OP_CALL: begin
                            mem_wdata = bus.req_pc[31:16];
                            if (overflow) begin
                                fault_set = 1'b1;
                            end else begin
                                mem_write     = 1'b1;
                                stall         = 1'b1;
                                sp_dec        = 1'b1;
                                next_state    = ST_SECOND;
                                next_held_ret = 1'b0;
                            end
                        end
                        OP_RET: begin
                            mem_addr = sp_plus1;
                            if (underflow) begin
                                fault_set = 1'b1;
                            end else begin
                                mem_read      = 1'b1;
                                latch_en      = 1'b1;
                                stall         = 1'b1;
                                sp_inc        = 1'b1;
                                next_state    = ST_SECOND;
                                next_held_ret = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_SECOND: begin
                next_state = ST_IDLE;
                if (held_ret) begin
                    mem_addr = sp_plus1;
                    if (underflow) begin
                        fault_set = 1'b1;
                    end else begin
                        mem_read     = 1'b1;
                        ret_pc_valid = 1'b1;
                        sp_inc       = 1'b1;
                    end
                end else begin
                    mem_wdata = bus.req_pc[15:0];
                    if (overflow) begin
                        fault_set = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        sp_dec    = 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (Reset) begin
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            rd_valid     = 1'b0;
            ret_pc_valid = 1'b0;
            stall        = 1'b0;
            sp_inc       = 1'b0;
            sp_dec       = 1'b0;
            latch_en     = 1'b0;
            fault_set    = 1'b0;
        end
    end

    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.mem_read     = mem_read;
    assign bus.mem_write    = mem_write;
    assign bus.rd_data      = bus.mem_rdata;
    assign bus.rd_valid     = rd_valid;
    assign bus.ret_pc       = {bus.mem_rdata, low_half};
    assign bus.ret_pc_valid = ret_pc_valid;
    assign bus.stall        = stall;
    assign bus.sp           = sp;
    assign bus.stack_fault  = fault_q;

endmodule

// File: tb/tb_stack_access_sequencer.sv
// Directed testbench for stack_access_sequencer with a behavioural
// 16-bit data memory (combinational read, write on the rising edge).
module tb_stack_access_sequencer;
    import stack_access_sequencer_pkg::*;

    logic CLK;
    logic Reset;
    int   n_cmp;
    int   n_bad;

    logic [15:0] mem [0:65535];

    stack_access_sequencer_if bus ();

    stack_access_sequencer dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.mem_rdata = mem[bus.mem_addr[15:0]];

    always @(posedge CLK) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[15:0]] <= bus.mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [31:0] pc);
        bus.req_valid = valid;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = pc;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b1;
        applyStimulus(1'b0, OP_NONE, 16'h0, 16'h0, 32'h0);

        nextCycle();
        applyStimulus(1'b1, OP_PUSH, 16'h0, 16'h1111, 32'h0);
        checkOutput("rst_write", {31'h0, bus.mem_write}, 32'd0);
        checkOutput("rst_stall", {31'h0, bus.stall}, 32'd0);
        checkOutput("rst_sp", bus.sp, 32'h0000_0FFF);
        checkOutput("rst_fault", {31'h0, bus.stack_fault}, 32'd0);

        nextCycle();
        Reset = 1'b0;
        applyStimulus(1'b1, OP_PUSH, 16'h0, 16'hAAAA, 32'h0);
        checkOutput("push_write", {31'h0, bus.mem_write}, 32'd1);
        checkOutput("push_addr", bus.mem_addr, 32'h0000_0FFF);
        checkOutput("push_wdata", {16'h0, bus.mem_wdata}, 32'h0000_AAAA);

        nextCycle();
        checkOutput("push_sp", bus.sp, 32'h0000_0FFE);
        checkOutput("push_mem", {16'h0, mem[16'h0FFF]}, 32'h0000_AAAA);
        applyStimulus(1'b1, OP_POP, 16'h0, 16'h0, 32'h0);
        checkOutput("pop_read", {31'h0, bus.mem_read}, 32'd1);
        checkOutput("pop_addr", bus.mem_addr, 32'h0000_0FFF);
        checkOutput("pop_valid", {31'h0, bus.rd_valid}, 32'd1);
        checkOutput("pop_data", {16'h0, bus.rd_data}, 32'h0000_AAAA);

        nextCycle();
        checkOutput("pop_sp", bus.sp, 32'h0000_0FFF);
        applyStimulus(1'b1, OP_CALL, 16'h0, 16'h0, 32'h1234_5678);
        checkOutput("call1_stall", {31'h0, bus.stall}, 32'd1);
        checkOutput("call1_write", {31'h0, bus.mem_write}, 32'd1);
        checkOutput("call1_addr", bus.mem_addr, 32'h0000_0FFF);
        checkOutput("call1_wdata", {16'h0, bus.mem_wdata}, 32'h0000_1234);

        nextCycle();
        checkOutput("call2_stall", {31'h0, bus.stall}, 32'd0);
        checkOutput("call2_write", {31'h0, bus.mem_write}, 32'd1);
        checkOutput("call2_addr", bus.mem_addr, 32'h0000_0FFE);
        checkOutput("call2_wdata", {16'h0, bus.mem_wdata}, 32'h0000_5678);

        nextCycle();
        checkOutput("call_sp", bus.sp, 32'h0000_0FFD);
        checkOutput("call_mem_hi", {16'h0, mem[16'h0FFF]}, 32'h0000_1234);
        checkOutput("call_mem_lo", {16'h0, mem[16'h0FFE]}, 32'h0000_5678);
        applyStimulus(1'b1, OP_RET, 16'h0, 16'h0, 32'h0);
        checkOutput("ret1_read", {31'h0, bus.mem_read}, 32'd1);
        checkOutput("ret1_addr", bus.mem_addr, 32'h0000_0FFE);
        checkOutput("ret1_stall", {31'h0, bus.stall}, 32'd1);
        checkOutput("ret1_pcvalid", {31'h0, bus.ret_pc_valid}, 32'd0);

        nextCycle();
        checkOutput("ret2_stall", {31'h0, bus.stall}, 32'd0);
        checkOutput("ret2_addr", bus.mem_addr, 32'h0000_0FFF);
        checkOutput("ret2_pcvalid", {31'h0, bus.ret_pc_valid}, 32'd1);
        checkOutput("ret2_pc", bus.ret_pc, 32'h1234_5678);

        nextCycle();
        checkOutput("ret_sp", bus.sp, 32'h0000_0FFF);
        applyStimulus(1'b1, OP_STORE, 16'h0040, 16'hBEEF, 32'h0);
        checkOutput("store_addr", bus.mem_addr, 32'h0000_0040);
        checkOutput("store_write", {31'h0, bus.mem_write}, 32'd1);
        checkOutput("store_wdata", {16'h0, bus.mem_wdata}, 32'h0000_BEEF);

        nextCycle();
        applyStimulus(1'b1, OP_LOAD, 16'h0040, 16'h0, 32'h0);
        checkOutput("load_addr", bus.mem_addr, 32'h0000_0040);
        checkOutput("load_read", {31'h0, bus.mem_read}, 32'd1);
        checkOutput("load_valid", {31'h0, bus.rd_valid}, 32'd1);
        checkOutput("load_data", {16'h0, bus.rd_data}, 32'h0000_BEEF);
        checkOutput("load_sp", bus.sp, 32'h0000_0FFF);

        nextCycle();
        applyStimulus(1'b1, OP_CALL, 16'h0, 16'h0, 32'hAABB_CCDD);
        checkOutput("call_b1_stall", {31'h0, bus.stall}, 32'd1);

        nextCycle();
        Reset = 1'b1;
        #1;
        checkOutput("rstmid_write", {31'h0, bus.mem_write}, 32'd0);
        checkOutput("rstmid_stall", {31'h0, bus.stall}, 32'd0);

        nextCycle();
        Reset = 1'b0;
        applyStimulus(1'b0, OP_NONE, 16'h0, 16'h0, 32'h0);
        checkOutput("rstmid_mem_hi", {16'h0, mem[16'h0FFF]}, 32'h0000_AABB);
        checkOutput("rstmid_mem_lo", {16'h0, mem[16'h0FFE]}, 32'h0000_5678);
        checkOutput("rstmid_sp", bus.sp, 32'h0000_0FFF);
        checkOutput("rstmid_idle_stall", {31'h0, bus.stall}, 32'd0);
        checkOutput("rstmid_idle_write", {31'h0, bus.mem_write}, 32'd0);

        nextCycle();
        applyStimulus(1'b1, OP_POP, 16'h0, 16'h0, 32'h0);
`ifdef STACK_GUARD_EN
        checkOutput("guard_read", {31'h0, bus.mem_read}, 32'd0);
        checkOutput("guard_valid", {31'h0, bus.rd_valid}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, OP_NONE, 16'h0, 16'h0, 32'h0);
        checkOutput("guard_fault", {31'h0, bus.stack_fault}, 32'd1);
        checkOutput("guard_sp", bus.sp, 32'h0000_0FFF);
        nextCycle();
        checkOutput("guard_fault_held", {31'h0, bus.stack_fault}, 32'd1);
`else
        checkOutput("wrap_read", {31'h0, bus.mem_read}, 32'd1);
        checkOutput("wrap_addr", bus.mem_addr, 32'h0000_1000);
        checkOutput("wrap_valid", {31'h0, bus.rd_valid}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, OP_NONE, 16'h0, 16'h0, 32'h0);
        checkOutput("wrap_sp", bus.sp, 32'h0000_1000);
        checkOutput("wrap_fault", {31'h0, bus.stack_fault}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
